// File: rtl/pipeline_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_pkg
// Shared definitions for the five-stage pipeline execution controller:
// state codes, debug command codes, default parameter values and a small
// helper that tells whether a state enables the pipeline registers.
// -----------------------------------------------------------------------------
package pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    // Command codes 5..7 are reserved and ignored by the sequencer.
    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_STEP  = 3'd2;
    localparam logic [2:0] CMD_STOP  = 3'd3;
    localparam logic [2:0] CMD_FLUSH = 3'd4;

    localparam int DEF_COUNTER_SIZE = 32;
    localparam int DEF_FLUSH_CYCLES = 5;
    localparam int DEF_PC_SIZE      = 32;

    function automatic logic state_enables(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_if
// Debug-unit command handshake. A command is taken on a clock edge where
// cmd_valid and cmd_ready are both high.
//   cmd_valid : command strobe            (master -> slave)
//   cmd       : 3-bit command code        (master -> slave)
//   cmd_ready : sequencer can take a cmd  (slave  -> master)
// -----------------------------------------------------------------------------
interface pipeline_sequencer_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd, output cmd_ready);
endinterface

// File: rtl/pipeline_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear and enable that sticks at all ones.
//   i_clk    : clock
//   i_clear  : synchronous clear (wins over enable)
//   i_enable : count this cycle
//   o_count  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Execution controller for the five-stage pipeline. Drives the common enable
// and synchronous flush of all pipeline registers; runs, single-steps or stops
// the pipeline on HALT, and counts enabled cycles.
//
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   io_cmd           : debug command handshake (slave side)
//   i_halt           : HALT flag at the MEM/WB register input
//   o_enable         : enable to every pipeline register
//   o_flush          : synchronous clear to every pipeline register
//   o_done           : one-cycle completion pulse
//   o_state          : current state code
//   o_cycle_count    : enabled cycles since last flush or reset
// Optional (macro PIPELINE_SEQUENCER_BREAKPOINT_EN):
//   i_pc, i_bp_addr, i_bp_valid : breakpoint compare at IF
//   o_bp_hit                    : one-cycle pulse on a breakpoint stop
// -----------------------------------------------------------------------------
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int PC_SIZE      = DEF_PC_SIZE
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    pipeline_sequencer_if.slave     io_cmd,
    input  logic                    i_halt,
`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
    input  logic [PC_SIZE-1:0]      i_pc,
    input  logic [PC_SIZE-1:0]      i_bp_addr,
    input  logic                    i_bp_valid,
    output logic                    o_bp_hit,
`endif
    output logic                    o_enable,
    output logic                    o_flush,
    output logic                    o_done,
    output logic [2:0]              o_state,
    output logic [COUNTER_SIZE-1:0] o_cycle_count
);

    localparam int             FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0]  FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    if (COUNTER_SIZE < 1 || FLUSH_CYCLES < 1 || PC_SIZE < 1) begin : g_param_check
        $error("pipeline_sequencer: parameters must be positive");
    end

    state_e         r_state;
    state_e         w_next;
    logic           w_done_nxt;
    logic           w_ready;
    logic           w_accept;
    logic           w_enable;
    logic           w_flush_entry;
    logic           w_bp_match;
    logic           r_done;
    logic [FW-1:0]  r_flush_cnt;

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign w_accept = io_cmd.cmd_valid && w_ready;
    assign w_enable = state_enables(r_state);

`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
    logic r_bp_hit;
    assign w_bp_match = i_bp_valid && (i_pc == i_bp_addr);
`else
    assign w_bp_match = 1'b0;
`endif

    // Next state and the completion pulse to be registered with it.
    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (io_cmd.cmd == CMD_RUN)        w_next = ST_RUN;
                    else if (io_cmd.cmd == CMD_STEP)  w_next = ST_STEP;
                    else if (io_cmd.cmd == CMD_FLUSH) w_next = ST_FLUSH;
                end
            end
            ST_RUN: begin
                // Halt outranks breakpoint, which outranks a debugger STOP.
                if (i_halt) begin
                    w_next     = ST_HALTED;
                    w_done_nxt = 1'b1;
                end else if (w_bp_match) begin
                    w_next     = ST_IDLE;
                    w_done_nxt = 1'b1;
                end else if (w_accept && io_cmd.cmd == CMD_STOP) begin
                    w_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_next     = i_halt ? ST_HALTED : ST_IDLE;
                w_done_nxt = 1'b1;
            end
            ST_HALTED: begin
                if (w_accept && io_cmd.cmd == CMD_FLUSH) w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_next     = ST_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_flush_entry = (w_next == ST_FLUSH) && (r_state != ST_FLUSH);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_nxt;
            if (w_flush_entry) begin
                r_flush_cnt <= FLUSH_LOAD;
            end else if (r_state == ST_FLUSH && r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - FW'(1);
            end
        end
    end

`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= (r_state == ST_RUN) && !i_halt && w_bp_match;
        end
    end
    assign o_bp_hit = r_bp_hit;
`endif

    // Count clears on the edge that enters FLUSH; pipeline is never enabled then.
    sat_counter #(.WIDTH(COUNTER_SIZE)) u_cycle_counter (
        .i_clk    (i_clk),
        .i_clear  (i_reset || w_flush_entry),
        .i_enable (w_enable),
        .o_count  (o_cycle_count)
    );

    assign io_cmd.cmd_ready = w_ready;
    assign o_enable         = w_enable;
    assign o_flush          = (r_state == ST_FLUSH);
    assign o_done           = r_done;
    assign o_state          = r_state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
// Two sequencers: A with default parameters, B with a 4-bit counter and a
// one-cycle flush. Both are compared each cycle against a behavioural model
// built from the state rules, plus directed constant expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    typedef struct {
        int     st;    // 0 idle, 1 run, 2 step, 3 halted, 4 flush
        int     fl;    // flush cycles still to go
        longint cnt;
        bit     done;
        bit     bp;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pipeline_sequencer_if ifa();
    pipeline_sequencer_if ifb();

    logic        ra, rb, halt_a, halt_b;
    logic [2:0]  st_a, st_b;
    logic        en_a, en_b, fl_a, fl_b, dn_a, dn_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [31:0] pc, bp_addr;
    logic        bpv_a, bpv_b, bph_a, bph_b;

    mdl_t ma, mb;

    pipeline_sequencer dut_a (
        .i_clk(clk), .i_reset(ra), .io_cmd(ifa), .i_halt(halt_a),
`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
        .i_pc(pc), .i_bp_addr(bp_addr), .i_bp_valid(bpv_a), .o_bp_hit(bph_a),
`endif
        .o_enable(en_a), .o_flush(fl_a), .o_done(dn_a), .o_state(st_a),
        .o_cycle_count(cnt_a)
    );

    pipeline_sequencer #(.COUNTER_SIZE(4), .FLUSH_CYCLES(1)) dut_b (
        .i_clk(clk), .i_reset(rb), .io_cmd(ifb), .i_halt(halt_b),
`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
        .i_pc(pc), .i_bp_addr(bp_addr), .i_bp_valid(bpv_b), .o_bp_hit(bph_b),
`endif
        .o_enable(en_b), .o_flush(fl_b), .o_done(dn_b), .o_state(st_b),
        .o_cycle_count(cnt_b)
    );

    // Reference behaviour for one clock edge.
    function automatic mdl_t mstep(mdl_t m, bit rst, bit vld, int cmd, bit halt,
                                   bit bph, int fcyc, longint cmax);
        mdl_t n;
        bit   acc;
        n      = m;
        n.done = 1'b0;
        n.bp   = 1'b0;
        if (rst) begin
            n.st = 0; n.fl = 0; n.cnt = 0;
            return n;
        end
        acc = vld && (m.st == 0 || m.st == 1 || m.st == 3);
        if (m.st == 1 || m.st == 2) n.cnt = (m.cnt >= cmax) ? cmax : m.cnt + 1;
        case (m.st)
            0: if (acc) begin
                   if (cmd == 1) n.st = 1;
                   else if (cmd == 2) n.st = 2;
                   else if (cmd == 4) begin n.st = 4; n.fl = fcyc; n.cnt = 0; end
               end
            1: if (halt) begin n.st = 3; n.done = 1; end
               else if (bph) begin n.st = 0; n.done = 1; n.bp = 1; end
               else if (acc && cmd == 3) n.st = 0;
            2: begin n.st = halt ? 3 : 0; n.done = 1; end
            3: if (acc && cmd == 4) begin n.st = 4; n.fl = fcyc; n.cnt = 0; end
            4: begin
                   n.fl = m.fl - 1;
                   if (n.fl == 0) begin n.st = 0; n.done = 1; end
               end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    task automatic expect_c(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(string tag, logic [2:0] st, logic en, logic fl, logic rdy,
                       logic dn, logic [63:0] cnt, mdl_t m);
        expect_c({tag, "_state"}, 64'(st), 64'(m.st));
        expect_c({tag, "_enable"}, 64'(en), 64'(m.st == 1 || m.st == 2));
        expect_c({tag, "_flush"}, 64'(fl), 64'(m.st == 4));
        expect_c({tag, "_ready"}, 64'(rdy), 64'(m.st == 0 || m.st == 1 || m.st == 3));
        expect_c({tag, "_done"}, 64'(dn), 64'(m.done));
        expect_c({tag, "_count"}, cnt, 64'(m.cnt));
    endtask

    task automatic tick();
        bit bpa, bpb;
        bpa = 1'b0;
        bpb = 1'b0;
`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
        bpa = bpv_a && (pc == bp_addr);
        bpb = bpv_b && (pc == bp_addr);
`endif
        ma = mstep(ma, ra, ifa.cmd_valid, int'(ifa.cmd), halt_a, bpa, 5, 64'hFFFF_FFFF);
        mb = mstep(mb, rb, ifb.cmd_valid, int'(ifb.cmd), halt_b, bpb, 1, 15);
        @(posedge clk);
        #1;
        chk("A", st_a, en_a, fl_a, ifa.cmd_ready, dn_a, 64'(cnt_a), ma);
        chk("B", st_b, en_b, fl_b, ifb.cmd_ready, dn_b, 64'(cnt_b), mb);
`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
        expect_c("A_bp_hit", 64'(bph_a), 64'(ma.bp));
        expect_c("B_bp_hit", 64'(bph_b), 64'(mb.bp));
`endif
    endtask

    task automatic cmd_a(logic [2:0] c);
        ifa.cmd_valid = 1'b1;
        ifa.cmd       = c;
        tick();
        ifa.cmd_valid = 1'b0;
    endtask

    initial begin
        ma = '{st: 0, fl: 0, cnt: 0, done: 0, bp: 0};
        mb = ma;
        ra = 1'b1; rb = 1'b1; halt_a = 1'b0; halt_b = 1'b0;
        ifa.cmd_valid = 1'b0; ifa.cmd = 3'd0;
        ifb.cmd_valid = 1'b0; ifb.cmd = 3'd0;
        pc = 32'h0; bp_addr = 32'h40; bpv_a = 1'b0; bpv_b = 1'b0;

        // Reset state
        tick();
        ra = 1'b0; rb = 1'b0;
        expect_c("rst_state", 64'(st_a), 64'd0);
        expect_c("rst_ready", 64'(ifa.cmd_ready), 64'd1);
        expect_c("rst_count", 64'(cnt_a), 64'd0);
        tick();

        // RUN, halt seen after eight enabled cycles
        cmd_a(3'd1);
        repeat (7) tick();
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        expect_c("halt_state", 64'(st_a), 64'd3);
        expect_c("halt_done", 64'(dn_a), 64'd1);
        expect_c("halt_enable", 64'(en_a), 64'd0);
        expect_c("halt_count", 64'(cnt_a), 64'd8);

        // From HALTED: RUN is dropped, FLUSH holds o_flush five cycles
        cmd_a(3'd1);
        expect_c("halted_run_dropped", 64'(st_a), 64'd3);
        cmd_a(3'd4);
        expect_c("flush_count_clear", 64'(cnt_a), 64'd0);
        for (int i = 0; i < 5; i++) begin
            expect_c("flush_held", 64'(fl_a), 64'd1);
            tick();
        end
        expect_c("flush_exit_state", 64'(st_a), 64'd0);
        expect_c("flush_exit_done", 64'(dn_a), 64'd1);
        expect_c("flush_exit_flush", 64'(fl_a), 64'd0);

        // Three STEPs with valid held high
        ifa.cmd_valid = 1'b1; ifa.cmd = 3'd2;
        repeat (6) tick();
        ifa.cmd_valid = 1'b0;
        expect_c("step_count", 64'(cnt_a), 64'd3);
        expect_c("step_state", 64'(st_a), 64'd0);

        // Halt and STOP in the same RUN cycle: halt wins
        cmd_a(3'd1);
        halt_a = 1'b1;
        cmd_a(3'd3);
        halt_a = 1'b0;
        expect_c("halt_over_stop", 64'(st_a), 64'd3);

        // Reset mid-FLUSH
        cmd_a(3'd4);
        tick();
        ra = 1'b1;
        tick();
        ra = 1'b0;
        expect_c("rst_flush_state", 64'(st_a), 64'd0);
        expect_c("rst_flush_flush", 64'(fl_a), 64'd0);

        // Reset mid-RUN clears the counter
        cmd_a(3'd1);
        repeat (3) tick();
        ra = 1'b1;
        tick();
        ra = 1'b0;
        expect_c("rst_run_count", 64'(cnt_a), 64'd0);
        expect_c("rst_run_enable", 64'(en_a), 64'd0);

`ifdef PIPELINE_SEQUENCER_BREAKPOINT_EN
        // Breakpoint at 0x40 reached while running
        bpv_a = 1'b1;
        pc    = 32'h30;
        cmd_a(3'd1);
        for (int i = 0; i < 4; i++) begin
            pc = pc + 32'd4;
            tick();
        end
        expect_c("bp_state", 64'(st_a), 64'd0);
        expect_c("bp_hit", 64'(bph_a), 64'd1);
        expect_c("bp_done", 64'(dn_a), 64'd1);
        bpv_a = 1'b0;
        pc    = 32'h0;
`endif

        // 4-bit counter saturates after 20 RUN cycles
        ifb.cmd_valid = 1'b1; ifb.cmd = 3'd1;
        tick();
        ifb.cmd_valid = 1'b0;
        repeat (20) tick();
        expect_c("sat_count", 64'(cnt_b), 64'd15);
        expect_c("sat_state", 64'(st_b), 64'd1);

        // Randomized traffic on both instances
        for (int i = 0; i < 800; i++) begin
            ra = ($urandom_range(0, 99) == 0);
            rb = ($urandom_range(0, 99) == 0);
            halt_a = ($urandom_range(0, 9) == 0);
            halt_b = ($urandom_range(0, 9) == 0);
            ifa.cmd_valid = $urandom_range(0, 1) == 1;
            ifb.cmd_valid = $urandom_range(0, 1) == 1;
            ifa.cmd = 3'($urandom_range(0, 7));
            ifb.cmd = 3'($urandom_range(0, 7));
            pc      = 32'h3C + 32'($urandom_range(0, 2)) * 32'd4;
            bpv_a   = $urandom_range(0, 3) == 0;
            bpv_b   = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
